// File: rtl/filter_row_packer.sv
// Packs three consecutive filter weights into one row packet tagged with a 0/1/2 row select.
// Up to two rows are buffered: one in the output register and one held in the assembly lanes.
module filter_row_packer #(
  parameter int FILTER_WIDTH = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FILTER_WIDTH-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [3*FILTER_WIDTH-1:0] out_packet,
  output logic [1:0]                out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      filter_done,
  output logic [CNT_WIDTH-1:0]      filter_count
);

  logic [FILTER_WIDTH-1:0] lane0;
  logic [FILTER_WIDTH-1:0] lane1;
  logic [FILTER_WIDTH-1:0] lane2;
  logic [1:0]              byte_cnt;
  logic [1:0]              row_cnt;
  logic [1:0]              row_next;
  logic                    asm_full;
  logic                    in_fire;
  logic                    out_fire;
  logic                    out_free;

  // in_ready comes straight from a register so out_ready never reaches it combinationally.
  assign in_ready = !asm_full;
  assign in_fire  = in_valid && !asm_full;
  assign out_fire = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;
  assign row_next = (row_cnt == 2'd2) ? 2'd0 : row_cnt + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane0      <= '0;
      lane1      <= '0;
      lane2      <= '0;
      byte_cnt   <= 2'd0;
      row_cnt    <= 2'd0;
      asm_full   <= 1'b0;
      out_packet <= '0;
      out_sel    <= 2'd0;
      out_valid  <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid <= 1'b0;
      end
      // A held row has priority; no weight can arrive while it is held.
      if (asm_full) begin
        if (out_free) begin
          out_packet <= {lane2, lane1, lane0};
          out_sel    <= row_cnt;
          out_valid  <= 1'b1;
          row_cnt    <= row_next;
          asm_full   <= 1'b0;
          byte_cnt   <= 2'd0;
        end
      end else if (in_fire) begin
        case (byte_cnt)
          2'd0: begin
            lane0    <= in_data;
            byte_cnt <= 2'd1;
          end
          2'd1: begin
            lane1    <= in_data;
            byte_cnt <= 2'd2;
          end
          default: begin
            if (out_free) begin
              out_packet <= {in_data, lane1, lane0};
              out_sel    <= row_cnt;
              out_valid  <= 1'b1;
              row_cnt    <= row_next;
              byte_cnt   <= 2'd0;
            end else begin
              lane2    <= in_data;
              asm_full <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Completion is signalled the cycle after the row-2 packet leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      filter_done  <= 1'b0;
      filter_count <= '0;
    end else begin
      filter_done <= out_fire && (out_sel == 2'd2);
      if (out_fire && (out_sel == 2'd2)) begin
        filter_count <= filter_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/filter_row_packer.md
# filter_row_packer

Clocked upstream stage of the PE filter path. Accepts filter weights one element per handshake, packs every three consecutive weights into one `3*FILTER_WIDTH`-bit row packet, and tags each packet with a 2-bit row select. Row select cycles 0, 1, 2 for the three rows of a 3x3 filter. The packet/select pair feeds the three-way row splitter directly: that splitter consumes one packet and one select together and routes row 0/1/2 to its R0/R1/R2 outputs. This block never emits select value 2'b11.

## Interface
Parameters:
- `FILTER_WIDTH`, default 8: width of one filter weight.
- `CNT_WIDTH`, default 16: width of the completed-filter counter.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `in_data`  input  FILTER_WIDTH  incoming weight.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block can accept a weight this cycle.
- `out_packet`  output  3*FILTER_WIDTH  packed row.
- `out_sel`  output  2  row index of `out_packet` (0, 1 or 2).
- `out_valid`  output  1  `out_packet`/`out_sel` are valid.
- `out_ready`  input  1  downstream accepts this cycle.
- `filter_done`  output  1  one-cycle pulse when a row-2 packet handshakes.
- `filter_count`  output  CNT_WIDTH  number of complete filters delivered; wraps modulo 2^CNT_WIDTH.

## Operation
- Input handshake: a transfer occurs when `in_valid && in_ready` is sampled high at a rising edge. Output handshake: a transfer occurs when `out_valid && out_ready` is sampled high.
- Storage:
  - assembly register: 3 lanes, `byte_cnt` 0..2, `asm_full` flag.
  - output register: packet, sel, `out_valid`.
  - `row_cnt` 0..2: row index of the next packet to be assembled.
- Lane packing: the 1st accepted weight goes to `[FILTER_WIDTH-1:0]`, the 2nd to `[2*FILTER_WIDTH-1:FILTER_WIDTH]`, the 3rd to `[3*FILTER_WIDTH-1:2*FILTER_WIDTH]`.
- `in_ready = !asm_full`. This is a registered flag with no combinational path from `out_ready`.
- When the 3rd weight is accepted:
  - If the output register is free this cycle (`!out_valid`, or an output handshake in the same cycle), the assembled row plus the 3rd weight load into the output register with `out_sel = row_cnt`. `row_cnt` advances; 2 wraps to 0. `byte_cnt` returns to 0.
  - Otherwise the assembly register holds the full row and `asm_full` is set.
- While `asm_full`: on the first cycle the output register is free, the held row transfers with `out_sel = row_cnt`. `row_cnt` advances, `asm_full` clears and `byte_cnt` returns to 0.
- Output register holds `out_packet`/`out_sel` stable while `out_valid && !out_ready`.
- Output handshake with `out_sel == 2` → next cycle `filter_done` = 1 for exactly one cycle and `filter_count` increments.
- Ordering: packets leave in exact arrival order. No packet is dropped or duplicated.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `out_valid` = 0, `out_packet` = 0, `out_sel` = 0
  - `in_ready` = 1, `filter_done` = 0, `filter_count` = 0
  - `byte_cnt` = 0, `row_cnt` = 0, `asm_full` = 0
- Reset mid-operation discards any partial row and any pending packet. The next accepted weight is lane 0 of a row-0 packet.
- Latency: 3rd weight accepted at edge N with the output register free → `out_valid` high after edge N (visible in cycle N+1).
- Throughput: one packet per 3 input handshakes, with no bubbles when `out_ready` stays high.
- Simultaneous events:
  - Output handshake and 3rd-weight acceptance in the same edge → the new packet loads with no idle cycle.
  - Output handshake and transfer of a held `asm_full` row in the same edge → the held row loads, and `in_ready` rises the next cycle.
- Capacity: at most 2 rows buffered (1 in the output register, 1 in assembly). A 7th weight cannot be accepted while both are full.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all outputs at reset values; `in_ready`=1.
- Single filter: `out_ready`=1, feed weights 0x01..0x09 back-to-back → packets 0x030201/sel0, 0x060504/sel1, 0x090807/sel2. `filter_done` pulses once; `filter_count`=1.
- Backpressure: `out_ready`=0, feed 0x11..0x16 → `out_packet`=0x131211/sel0 held stable; `in_ready`=0 after 6th weight. Raise `out_ready` → 0x161514/sel1 follows with no gap; `in_ready` returns to 1.
- Wrap: 2 filters (18 weights) with random `out_ready` → sel sequence 0,1,2,0,1,2; `filter_count`=2; 2 `filter_done` pulses.
- Reset mid-row: feed 0xA1..0xA4, assert `rst` 1 cycle, feed 0xB1..0xB3 → only packet 0xB3B2B1/sel0 appears; `filter_count`=0.
- Same-edge handoff: output register full, `out_ready` rises on the same edge the 3rd weight 0xC3 is accepted → next cycle `out_packet` = 0xC3C2C1 with `out_valid` continuously high.
